// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and output bundle, used by the sync
// generator and the downstream colour stage.
package vga_timing_pkg;

  localparam int CNT_W = 10;  // h/v count width
  localparam int FC_W  = 8;   // frame counter width

  localparam int VGA_CLK_DIV     = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_ACT_START = 144;
  localparam int VGA_H_ACT_END   = 784;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_ACT_START = 35;
  localparam int VGA_V_ACT_END   = 515;

  // Registered per-pixel outputs of the sync generator
  typedef struct packed {
    logic             pixel_tick;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;
    logic [FC_W-1:0]  frame_count;
  } vga_out_t;

  // Idle/reset value: syncs deasserted (high), everything else zero
  localparam vga_out_t VGA_OUT_RST = '{
    pixel_tick: 1'b0, hsync: 1'b1, vsync: 1'b1, video_on: 1'b0,
    pixel_x: '0, pixel_y: '0, line_start: 1'b0, frame_start: 1'b0,
    frame_count: '0
  };

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate strobe: divides clk by CLK_DIV, tick high for one clk per period.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // Free-running divider 0..CLK_DIV-1
  always_ff @(posedge clk) begin
    if (rst)                  div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                      div <= div + 1'b1;
  end

  assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: h/v raster counters advanced on the pixel tick, with all
// outputs registered decodes of the counts taken on the tick edge.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACT_END   = VGA_H_ACT_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACT_END   = VGA_V_ACT_END
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SW   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SW   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_AS   = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] H_AE   = CNT_W'(H_ACT_END);
  localparam logic [CNT_W-1:0] V_AS   = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0] V_AE   = CNT_W'(V_ACT_END);

  logic             tick;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [FC_W-1:0]  frame_cnt;
  logic             h_act, v_act;
  vga_out_t         out_q;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Raster counters: h advances per tick, v and frame on the wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign h_act = (h_cnt >= H_AS) && (h_cnt < H_AE);
  assign v_act = (v_cnt >= V_AS) && (v_cnt < V_AE);

  // Output decode: level outputs load on the tick and hold, strobes last one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= VGA_OUT_RST;
    end else begin
      out_q.pixel_tick  <= tick;
      out_q.line_start  <= tick && (h_cnt == '0);
      out_q.frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        out_q.hsync       <= (h_cnt >= H_SW);
        out_q.vsync       <= (v_cnt >= V_SW);
        out_q.video_on    <= h_act && v_act;
        out_q.pixel_x     <= (h_act && v_act) ? (h_cnt - H_AS) : '0;
        out_q.pixel_y     <= (h_act && v_act) ? (v_cnt - V_AS) : '0;
        out_q.frame_count <= frame_cnt;
      end
    end
  end

  assign pixel_tick  = out_q.pixel_tick;
  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign video_on    = out_q.video_on;
  assign pixel_x     = out_q.pixel_x;
  assign pixel_y     = out_q.pixel_y;
  assign line_start  = out_q.line_start;
  assign frame_start = out_q.frame_start;
  assign frame_count = out_q.frame_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunk-timing instance runs >256 frames plus random
// resets, and a default-timing instance runs several full lines. Expected
// outputs come from a closed-form model of "clks since reset".
module tb_vga_sync_gen;

  // shrunk raster so whole frames (and the 256-frame wrap) fit in a short run
  localparam int S_CD  = 3;
  localparam int S_HT  = 10, S_HS = 2, S_HAS = 3, S_HAE = 9;
  localparam int S_VT  = 6,  S_VS = 2, S_VAS = 2, S_VAE = 5;
  localparam int S_FRM = S_CD * S_HT * S_VT;
  localparam int P1    = 3 + 260 * S_FRM;   // end of uninterrupted phase
  localparam int NCYC  = P1 + 15000;

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] px;
    logic [9:0] py;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_s = 1'b1, rst_d = 1'b1;

  logic       s_tick, s_hs, s_vs, s_von, s_ls, s_fs;
  logic [9:0] s_px, s_py;
  logic [7:0] s_fc;
  logic       d_tick, d_hs, d_vs, d_von, d_ls, d_fs;
  logic [9:0] d_px, d_py;
  logic [7:0] d_fc;

  exp_t q_s[$];
  exp_t q_d[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(S_CD), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_START(S_HAS),
    .H_ACT_END(S_HAE), .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_ACT_START(S_VAS),
    .V_ACT_END(S_VAE)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pixel_tick(s_tick), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_von), .pixel_x(s_px), .pixel_y(s_py), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst_d), .pixel_tick(d_tick), .hsync(d_hs), .vsync(d_vs),
    .video_on(d_von), .pixel_x(d_px), .pixel_y(d_py), .line_start(d_ls),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  // k = clk edges since the last edge that saw reset. The n-th pixel tick
  // lands on edge k = n*cd and presents pixel p = n-1 of the raster scan.
  function automatic exp_t model(int k, int cd, int ht, int hsw, int has,
                                 int hae, int vt, int vsw, int vas, int vae);
    exp_t e;
    int p, h, v;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (k < cd) return e;
    p = k / cd - 1;
    h = p % ht;
    v = (p / ht) % vt;
    e.tick = (k % cd == 0);
    e.hs   = (h >= hsw);
    e.vs   = (v >= vsw);
    e.von  = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
    if (e.von) begin
      e.px = 10'(h - has);
      e.py = 10'(v - vas);
    end
    e.ls = e.tick && (h == 0);
    e.fs = e.ls && (v == 0);
    e.fc = 8'((p / (ht * vt)) % 256);
    return e;
  endfunction

  // Monitor: compare every presented output cycle against the scoreboard
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        a = '{s_tick, s_hs, s_vs, s_von, s_px, s_py, s_ls, s_fs, s_fc};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL small_inst t=%0t got=%h want=%h", $time, a, e);
      end
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        a = '{d_tick, d_hs, d_vs, d_von, d_px, d_py, d_ls, d_fs, d_fc};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL default_inst t=%0t got=%h want=%h", $time, a, e);
      end
    end
  end

  // Stimulus: drive resets, advance the model, push expectations
  initial begin
    int k_s, k_d, left_s;
    k_s = 0;
    k_d = 0;
    left_s = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      k_s = rst_s ? 0 : k_s + 1;
      k_d = rst_d ? 0 : k_d + 1;
      q_s.push_back(model(k_s, S_CD, S_HT, S_HS, S_HAS, S_HAE,
                          S_VT, S_VS, S_VAS, S_VAE));
      q_d.push_back(model(k_d, 4, 800, 96, 144, 784, 525, 2, 35, 515));
      #1;
      // small instance: long clean run, one mid-frame pulse, then random resets
      if (c + 1 < 3) begin
        rst_s = 1'b1;
      end else if (c + 1 == P1) begin
        rst_s = 1'b1;
      end else if (left_s > 0) begin
        rst_s = 1'b1;
        left_s--;
      end else if (c + 1 > P1 && $urandom_range(0, 249) == 0) begin
        rst_s = 1'b1;
        left_s = $urandom_range(0, 2);
      end else begin
        rst_s = 1'b0;
      end
      // default instance: initial reset, then rare single-clk resets mid-line
      rst_d = (c + 1 < 2) || (c + 1 > 12000 && $urandom_range(0, 9999) == 0);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
